// File: rtl/order_content_arbiter_pkg.sv
// Shared definitions for the order content RAM controller: default geometry
// of the order content block RAM and the controller state encoding.
package order_content_arbiter_pkg;

   localparam int ORDER_ADDR_W = 12;
   localparam int ORDER_DATA_W = 793;
   localparam int ORDER_DEPTH  = 4096;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   typedef enum logic {
      S_CLEAR = ST_CLEAR,
      S_RUN   = ST_RUN
   } state_t;

endpackage

// File: rtl/order_rr_arb2.sv
// Two-input grant logic. Round-robin on ties by default (the requester that
// did not win last time wins), or requester 1 always wins on ties when
// FIXED_PRIO is non-zero. At most one grant per cycle, and only when enabled.
//
// Handshake: a requester holds reqN; gntN is combinational in the same cycle
// and a transfer happens in every cycle where reqN && gntN.
module order_rr_arb2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // 1 = requester 1 won the most recent grant; reset to 1 so requester 0
   // takes the first tie.
   logic last_grant;

   // Combinational grant selection for this cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
               gnt1 = 1'b1;
            end else if (last_grant) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Remember the winner, but only on an actual grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (gnt0) begin
         last_grant <= 1'b0;
      end else if (gnt1) begin
         last_grant <= 1'b1;
      end
   end

endmodule

// File: rtl/order_content_arbiter.sv
// Controller for the single-port order content RAM. After reset or a clear
// command it zeroes every entry (one write per cycle), then shares the RAM
// port between the order update path (requester 0, read/write) and the order
// lookup path (requester 1, read-only). The RAM has a 1-cycle registered,
// write-first read, so rsp_data is valid in the cycle after the grant and is
// tagged with rsp0_valid or rsp1_valid. There is no response backpressure.
module order_content_arbiter
   import order_content_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ORDER_ADDR_W,
   parameter int DATA_W     = ORDER_DATA_W,
   parameter int DEPTH      = ORDER_DEPTH,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              init_done,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   // One extra counter bit so the counter can never wrap before the terminal
   // compare fires.
   localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

   state_t            state, state_nxt;
   logic [ADDR_W:0]   clr_cnt, clr_nxt;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              arb_en;
   logic              gnt0, gnt1;

   assign arb_en     = (state == S_RUN);
   assign init_done  = (state == S_RUN);
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_data   = ram_dout;

   order_rr_arb2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .req0  (req0_valid),
      .req1  (req1_valid),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   // State, clear counter, held RAM address and response tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_CLEAR;
         clr_cnt    <= '0;
         ram_addr_q <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         clr_cnt    <= clr_nxt;
         ram_addr_q <= ram_addr;
         rsp0_valid <= gnt0;
         rsp1_valid <= gnt1;
      end
   end

   // Next state and RAM port drive: clear sweep in CLEAR, granted request in RUN.
   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      ram_we    = 1'b0;
      ram_addr  = ram_addr_q;
      ram_din   = '0;
      case (state)
         S_CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt[ADDR_W-1:0];
            if (clr_cnt == CLR_LAST) begin
               state_nxt = S_RUN;
               clr_nxt   = '0;
            end else begin
               clr_nxt = clr_cnt + CLR_ONE;
            end
         end
         S_RUN: begin
            if (gnt0) begin
               ram_addr = req0_addr;
               ram_we   = req0_we;
               ram_din  = req0_wdata;
            end else if (gnt1) begin
               ram_addr = req1_addr;
            end
            // A grant in this same cycle still completes; only the next
            // cycle starts clearing.
            if (clear_req) begin
               state_nxt = S_CLEAR;
            end
         end
         default: begin
            state_nxt = S_CLEAR;
         end
      endcase
   end

endmodule

// File: tb/tb_order_content_arbiter.sv
// Bench for order_content_arbiter with a behavioural write-first RAM. A
// reference memory and grant model predict each response; expectations are
// queued when a grant is expected and checked when the response is due.
module tb_order_content_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 793;
   localparam int DEPTH  = 4096;

   logic              clk;
   logic              reset;
   logic              clear_req;
   logic              init_done;
   logic              req0_valid, req0_ready, req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req1_valid, req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic              rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;
   logic [DATA_W-1:0] ram_dout;

   // Fixed-priority instance sharing the same request inputs.
   logic              fp_init_done, fp_req0_ready, fp_req1_ready;
   logic              fp_rsp0_valid, fp_rsp1_valid;
   logic [DATA_W-1:0] fp_rsp_data, fp_ram_din;
   logic [ADDR_W-1:0] fp_ram_addr;
   logic              fp_ram_we;
   logic [DATA_W-1:0] fp_ram_dout;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit tb_last  = 1'b1;

   logic [DATA_W-1:0] exp_q[$];
   logic              exp_id_q[$];
   int                exp_due_q[$];
   logic [DATA_W-1:0] ref_mem[int];
   logic [DATA_W-1:0] mem[0:DEPTH-1];
   logic [DATA_W-1:0] ones;

   order_content_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIXED_PRIO(0)
   ) dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .init_done(init_done),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
   );

   order_content_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIXED_PRIO(1)
   ) dut_fp (
      .clk(clk), .reset(reset), .clear_req(clear_req), .init_done(fp_init_done),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_addr(req1_addr),
      .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid), .rsp_data(fp_rsp_data),
      .ram_addr(fp_ram_addr), .ram_din(fp_ram_din), .ram_we(fp_ram_we),
      .ram_dout(fp_ram_dout)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port write-first RAM, 1-cycle registered read
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         ram_dout      <= ram_din;
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   // Scoreboard: pop the expectation due this cycle and compare the response
   always @(negedge clk) begin
      logic              ev;
      logic              eid;
      logic [DATA_W-1:0] ed;
      ev  = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
      eid = 1'b0;
      ed  = '0;
      if (ev) begin
         eid = exp_id_q.pop_front();
         ed  = exp_q.pop_front();
         void'(exp_due_q.pop_front());
      end
      if (ev || rsp0_valid || rsp1_valid) begin
         n_checks++;
         if (rsp0_valid === (ev && !eid) && rsp1_valid === (ev && eid) &&
             (!ev || rsp_data === ed) && !(rsp0_valid && rsp1_valid)) begin
            n_pass++;
         end else begin
            $display("FAIL rsp cyc=%0d got v0=%b v1=%b d=%h exp v=%b id=%b d=%h",
                     cyc, rsp0_valid, rsp1_valid, rsp_data[63:0], ev, eid, ed[63:0]);
         end
      end
   end

   function automatic logic [DATA_W-1:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return '0;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < 25; i++) r = (r << 32) | DATA_W'($urandom);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request cycle (called at posedge+1), predict grants with the
   // reference arbiter, and queue the expected response.
   task automatic drive_req(input logic v0, input logic we0,
                            input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                            input logic v1, input logic [ADDR_W-1:0] a1,
                            output logic g0, output logic g1);
      req0_valid = v0;
      req0_we    = we0;
      req0_addr  = a0;
      req0_wdata = d0;
      req1_valid = v1;
      req1_addr  = a1;
      g0 = v0 && (!v1 || tb_last);
      g1 = v1 && !g0;
      @(negedge clk);
      if (g0) begin
         exp_q.push_back(we0 ? d0 : ref_rd(int'(a0)));
         exp_id_q.push_back(1'b0);
         exp_due_q.push_back(cyc + 1);
         if (we0) ref_mem[int'(a0)] = d0;
         tb_last = 1'b0;
      end else if (g1) begin
         exp_q.push_back(ref_rd(int'(a1)));
         exp_id_q.push_back(1'b1);
         exp_due_q.push_back(cyc + 1);
         tb_last = 1'b1;
      end
   endtask

   task automatic idle_cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
   endtask

   // Walk one full clear sweep from posedge+1 of its first cycle, counting
   // cycles that deviate; optionally pulse clear_req partway through.
   task automatic scan_clear(input int pulse_at, output int bad, output int first_bad);
      bad = 0;
      first_bad = -1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == pulse_at) clear_req = 1'b1;
         @(negedge clk);
         if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(i) || init_done !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            if (bad == 0) first_bad = i;
            bad++;
         end
         tick();
         clear_req = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_reset();
      int bad, fb;
      reset = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0)
         $display("FAIL reset_state got init=%b v0=%b v1=%b exp 0 0 0", init_done, rsp0_valid, rsp1_valid);
      else n_pass++;
      tick();
      reset = 1'b0;
      tb_last = 1'b1;
      scan_clear(-1, bad, fb);
      n_checks++;
      if (bad !== 0) $display("FAIL clear_seq got %0d bad cycles first at %0d exp 0", bad, fb);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b1) $display("FAIL init_done_rise got %b exp 1", init_done);
      else n_pass++;
      tick();
   endtask

   task automatic test_read_cleared();
      logic g0, g1;
      drive_req(1'b0, 1'b0, '0, '0, 1'b1, 12'h7FF, g0, g1);
      n_checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
         $display("FAIL read_cleared_grant got r0=%b r1=%b exp 0 1", req0_ready, req1_ready);
      else n_pass++;
      tick();
      idle_cycle();
   endtask

   task automatic test_write_read();
      logic g0, g1;
      drive_req(1'b1, 1'b1, 12'h010, ones, 1'b0, '0, g0, g1);
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 12'h010)
         $display("FAIL write_grant got r0=%b r1=%b we=%b a=%h exp 1 0 1 010",
                  req0_ready, req1_ready, ram_we, ram_addr);
      else n_pass++;
      tick();
      drive_req(1'b0, 1'b0, '0, '0, 1'b1, 12'h010, g0, g1);
      n_checks++;
      if (req1_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h010)
         $display("FAIL read_grant got r1=%b we=%b a=%h exp 1 0 010", req1_ready, ram_we, ram_addr);
      else n_pass++;
      tick();
      idle_cycle();
      n_checks++;
      if (ram_addr !== 12'h010 || ram_we !== 1'b0)
         $display("FAIL addr_hold got a=%h we=%b exp 010 0", ram_addr, ram_we);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic g0, g1;
      for (int i = 0; i < 6; i++) begin
         drive_req(1'b1, 1'b1, ADDR_W'(12'h020 + i), rand_data(), 1'b1,
                   ADDR_W'(12'h020 + i - 1), g0, g1);
         n_checks++;
         if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
            $display("FAIL rr_grant i=%0d got r0=%b r1=%b exp r0=%b", i, req0_ready, req1_ready, (i % 2 == 0));
         else n_pass++;
         n_checks++;
         if (fp_req0_ready !== 1'b0 || fp_req1_ready !== 1'b1)
            $display("FAIL fixed_grant i=%0d got r0=%b r1=%b exp 0 1", i, fp_req0_ready, fp_req1_ready);
         else n_pass++;
         tick();
      end
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      logic g0, g1, v0, v1;
      int fails = 0;
      for (int i = 0; i < 40; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         drive_req(v0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(16, 23)), rand_data(),
                   v1, ADDR_W'($urandom_range(16, 23)), g0, g1);
         n_checks++;
         if (req0_ready !== g0 || req1_ready !== g1 ||
             fp_req1_ready !== v1 || fp_req0_ready !== (v0 && !v1)) begin
            fails++;
            $display("FAIL b2b_grant i=%0d got r0=%b r1=%b fp=%b%b exp %b%b fp=%b%b",
                     i, req0_ready, req1_ready, fp_req0_ready, fp_req1_ready, g0, g1, v0 && !v1, v1);
         end else n_pass++;
         tick();
      end
      idle_cycle();
   endtask

   task automatic test_clear_cmd();
      logic g0, g1;
      int bad, fb;
      clear_req = 1'b1;
      drive_req(1'b0, 1'b0, '0, '0, 1'b1, 12'h010, g0, g1);
      n_checks++;
      if (req1_ready !== 1'b1) $display("FAIL clear_cycle_grant got r1=%b exp 1", req1_ready);
      else n_pass++;
      ref_mem.delete();
      tick();
      clear_req = 1'b0;
      req1_valid = 1'b0;
      scan_clear(2000, bad, fb);
      n_checks++;
      if (bad !== 0) $display("FAIL clear_cmd_seq got %0d bad cycles first at %0d exp 0", bad, fb);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b1) $display("FAIL clear_cmd_done got %b exp 1", init_done);
      else n_pass++;
      tick();
      drive_req(1'b0, 1'b0, '0, '0, 1'b1, 12'h010, g0, g1);
      tick();
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      int bad, fb;
      req1_valid = 1'b1;
      req1_addr  = 12'h010;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req1_valid = 1'b0;
      tb_last = 1'b1;
      ref_mem.delete();
      n_checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0)
         $display("FAIL reset_drop got v0=%b v1=%b exp 0 0", rsp0_valid, rsp1_valid);
      else n_pass++;
      for (int i = 0; i < 1000; i++) tick();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ram_addr !== 12'd1000 || ram_we !== 1'b1)
         $display("FAIL clear_at_1000 got a=%0d we=%b exp 1000 1", ram_addr, ram_we);
      else n_pass++;
      tick();
      reset = 1'b0;
      tb_last = 1'b1;
      n_checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || init_done !== 1'b0)
         $display("FAIL reset_mid_state got v0=%b v1=%b init=%b exp 0 0 0", rsp0_valid, rsp1_valid, init_done);
      else n_pass++;
      scan_clear(-1, bad, fb);
      n_checks++;
      if (bad !== 0) $display("FAIL restart_seq got %0d bad cycles first at %0d exp 0", bad, fb);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b1) $display("FAIL restart_done got %b exp 1", init_done);
      else n_pass++;
      tick();
   endtask

   initial begin
      ones        = '1;
      fp_ram_dout = '0;
      reset       = 1'b1;
      clear_req   = 1'b0;
      req0_valid  = 1'b0;
      req0_we     = 1'b0;
      req0_addr   = '0;
      req0_wdata  = '0;
      req1_valid  = 1'b0;
      req1_addr   = '0;
      test_reset();
      test_read_cleared();
      test_write_read();
      test_round_robin();
      test_back_to_back();
      test_clear_cmd();
      test_reset_mid();
      idle_cycle();
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
